// File: rtl/icap_rb_pkg.sv
// Shared types and constants for the ICAP readback streamer: FSM states,
// datapath widths and the two TKEEP patterns the packer emits.
package icap_rb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } rb_state_t;

    localparam int ICAP_W = 32;
    localparam int AXIS_W = 64;
    localparam int KEEP_W = AXIS_W / 8;

    localparam logic [KEEP_W-1:0] TKEEP_FULL = 8'hFF;
    localparam logic [KEEP_W-1:0] TKEEP_HALF = 8'h0F;

endpackage

// File: rtl/icap_readback_streamer_if.sv
// Readback AXI-Stream toward the PCIe bridge. Handshake: a beat transfers on a
// rising edge where tvalid and tready are both high; once tvalid is raised,
// tdata/tkeep/tlast hold steady until that transfer, and tvalid never waits on tready.
interface icap_readback_streamer_if;
    import icap_rb_pkg::*;

    logic [AXIS_W-1:0] xRb_AXIS_tdata;
    logic [KEEP_W-1:0] xRb_AXIS_tkeep;
    logic              xRb_AXIS_tlast;
    logic              xRb_AXIS_tvalid;
    logic              xRb_AXIS_tready;

    modport master (
        output xRb_AXIS_tdata,
        output xRb_AXIS_tkeep,
        output xRb_AXIS_tlast,
        output xRb_AXIS_tvalid,
        input  xRb_AXIS_tready
    );

    modport slave (
        input  xRb_AXIS_tdata,
        input  xRb_AXIS_tkeep,
        input  xRb_AXIS_tlast,
        input  xRb_AXIS_tvalid,
        output xRb_AXIS_tready
    );

endinterface

// File: rtl/icap_rb_fifo.sv
// First-word-fall-through 32-bit FIFO exposing the two oldest words at once so
// the packer can pop a whole 64-bit beat; freeCount feeds the issue credit check.
module icap_rb_fifo
    import icap_rb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     push,
    input  logic [ICAP_W-1:0]        wrData,
    input  logic [1:0]               popCnt,
    output logic [ICAP_W-1:0]        rdData0,
    output logic [ICAP_W-1:0]        rdData1,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   freeCount
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ICAP_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;

    // Storage carries no reset; occupancy is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            rdPtr <= rdPtr + PTR_W'(popCnt);
            count <= count + CNT_W'(push) - CNT_W'(popCnt);
        end
    end

    assign rdData0   = mem[rdPtr];
    assign rdData1   = mem[rdPtr + PTR_W'(1)];
    assign freeCount = CNT_W'(DEPTH) - count;

endmodule

// File: rtl/icap_readback_streamer.sv
// Streams ICAPE3 readback words out as 64-bit AXI-Stream beats; read issue is
// credit-limited by FIFO space minus words still in the ICAP pipeline.
module icap_readback_streamer
    import icap_rb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int READ_LATENCY = 3,
    parameter int COUNT_W      = 24
) (
    input  logic                       AxiBusClock,
    input  logic                       xAxiBusReset_n,
    input  logic                       xCmdValid,
    output logic                       xCmdReady,
    input  logic [COUNT_W-1:0]         xCmdWordCount,
    output logic                       xIcapCsib,
    output logic                       xIcapRdwrb,
    input  logic                       xIcapAvail,
    input  logic [ICAP_W-1:0]          xIcapO,
    icap_readback_streamer_if.master   xRb,
    output logic                       xBusy,
    output logic                       xDone,
    output rb_state_t                  dbgState
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    rb_state_t state, stateNext;

    logic [COUNT_W-1:0]      remaining;
    logic [COUNT_W-1:0]      beatsLeft;
    logic                    lastOdd;
    logic [COUNT_W:0]        countPlusOne;
    logic [READ_LATENCY-1:0] inFlightSr;
    logic [LAT_W-1:0]        inFlight;
    logic                    cmdFire;
    logic                    issue;
    logic                    drainDone;

    logic [ICAP_W-1:0] rdData0, rdData1;
    logic [CNT_W-1:0]  fifoCount, fifoFree;
    logic [1:0]        popCnt;

    logic [AXIS_W-1:0] axisData;
    logic [KEEP_W-1:0] axisKeep;
    logic              axisLast;
    logic              axisValid;
    logic              beatFire;
    logic              loadBeat;
    logic              needOne;
    logic [COUNT_W-1:0] loadBeatsLeft;

    icap_rb_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
        .clk       (AxiBusClock),
        .rstN      (xAxiBusReset_n),
        .push      (inFlightSr[READ_LATENCY-1]),
        .wrData    (xIcapO),
        .popCnt    (popCnt),
        .rdData0   (rdData0),
        .rdData1   (rdData1),
        .count     (fifoCount),
        .freeCount (fifoFree)
    );

    always_comb begin
        inFlight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inFlight = inFlight + LAT_W'(inFlightSr[i]);
        end
    end

    assign cmdFire      = xCmdValid && (state == IDLE);
    assign countPlusOne = {1'b0, xCmdWordCount} + (COUNT_W + 1)'(1);
    // A slot is only spent when the FIFO can still absorb every word already in flight.
    assign issue        = (state == READ) && xIcapAvail && (remaining != '0)
                          && (fifoFree > CNT_W'(inFlight));
    assign beatFire     = axisValid && xRb.xRb_AXIS_tready;
    assign drainDone    = (inFlight == '0) && (fifoCount == '0)
                          && ((beatsLeft == '0) || (beatFire && axisLast));

    always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
        if (!xAxiBusReset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        xCmdReady  = (state == IDLE);
        xIcapCsib  = !issue;
        xIcapRdwrb = (state == SETUP) || (state == READ) || (state == DRAIN);
        xBusy      = (state == SETUP) || (state == READ) || (state == DRAIN) || (state == HOLD);
        xDone      = (state == DONE);
        case (state)
            IDLE:    if (cmdFire) stateNext = (xCmdWordCount != '0) ? SETUP : DONE;
            SETUP:   stateNext = READ;
            READ:    if (issue && (remaining == COUNT_W'(1))) stateNext = DRAIN;
            DRAIN:   if (drainDone) stateNext = HOLD;
            HOLD:    stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
        if (!xAxiBusReset_n) begin
            remaining  <= '0;
            beatsLeft  <= '0;
            lastOdd    <= 1'b0;
            inFlightSr <= '0;
        end else begin
            inFlightSr <= READ_LATENCY'({inFlightSr, issue});
            if (cmdFire) begin
                remaining <= xCmdWordCount;
                beatsLeft <= countPlusOne[COUNT_W:1];
                lastOdd   <= xCmdWordCount[0];
            end else begin
                if (issue) remaining <= remaining - COUNT_W'(1);
                if (beatFire) beatsLeft <= beatsLeft - COUNT_W'(1);
            end
        end
    end

    // Beats remaining once the beat now on the bus (if any) has gone.
    assign loadBeatsLeft = axisValid ? (beatsLeft - COUNT_W'(1)) : beatsLeft;
    assign needOne       = (loadBeatsLeft == COUNT_W'(1)) && lastOdd;
    assign loadBeat      = ((state == READ) || (state == DRAIN))
                           && (!axisValid || xRb.xRb_AXIS_tready)
                           && (loadBeatsLeft != '0)
                           && (needOne ? (fifoCount >= CNT_W'(1)) : (fifoCount >= CNT_W'(2)));
    assign popCnt        = loadBeat ? (needOne ? 2'd1 : 2'd2) : 2'd0;

    always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
        if (!xAxiBusReset_n) begin
            axisData  <= '0;
            axisKeep  <= '0;
            axisLast  <= 1'b0;
            axisValid <= 1'b0;
        end else if (loadBeat) begin
            axisValid <= 1'b1;
            axisData  <= {(needOne ? {ICAP_W{1'b0}} : rdData1), rdData0};
            axisKeep  <= needOne ? TKEEP_HALF : TKEEP_FULL;
            axisLast  <= (loadBeatsLeft == COUNT_W'(1));
        end else if (beatFire) begin
            axisValid <= 1'b0;
            axisLast  <= 1'b0;
        end
    end

    assign xRb.xRb_AXIS_tdata  = axisData;
    assign xRb.xRb_AXIS_tkeep  = axisKeep;
    assign xRb.xRb_AXIS_tlast  = axisLast;
    assign xRb.xRb_AXIS_tvalid = axisValid;
    assign dbgState            = state;

endmodule

// File: tb/tb_icap_readback_streamer.sv
// Directed bench for icap_readback_streamer: an ICAP read-latency model supplies
// numbered words and every emitted beat is checked against hand-derived values.
module tb_icap_readback_streamer;
    import icap_rb_pkg::*;

    localparam int FIFO_DEPTH   = 16;
    localparam int READ_LATENCY = 3;
    localparam int COUNT_W      = 24;

    logic               clk = 1'b0;
    logic               rstN = 1'b0;
    logic               xCmdValid;
    logic               xCmdReady;
    logic [COUNT_W-1:0] xCmdWordCount;
    logic               xIcapCsib;
    logic               xIcapRdwrb;
    logic               xIcapAvail;
    logic [31:0]        xIcapO;
    logic               xBusy;
    logic               xDone;
    rb_state_t          dbgState;

    icap_readback_streamer_if rbIf ();

    icap_readback_streamer #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .READ_LATENCY (READ_LATENCY),
        .COUNT_W      (COUNT_W)
    ) dut (
        .AxiBusClock    (clk),
        .xAxiBusReset_n (rstN),
        .xCmdValid      (xCmdValid),
        .xCmdReady      (xCmdReady),
        .xCmdWordCount  (xCmdWordCount),
        .xIcapCsib      (xIcapCsib),
        .xIcapRdwrb     (xIcapRdwrb),
        .xIcapAvail     (xIcapAvail),
        .xIcapO         (xIcapO),
        .xRb            (rbIf.master),
        .xBusy          (xBusy),
        .xDone          (xDone),
        .dbgState       (dbgState)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ICAP model: a word is presented READ_LATENCY cycles after each CSIB-low cycle.
    logic [READ_LATENCY:0] icapSr = '0;
    logic [31:0]           icapBase = '0;
    int                    icapIdx = 0;
    logic                  icapLoad = 1'b0;
    always @(negedge clk) begin
        if (!rstN) begin
            icapSr = '0;
            xIcapO = 32'hDEAD_BEEF;
        end else begin
            if (icapLoad) icapIdx = 0;
            icapSr = {icapSr[READ_LATENCY-1:0], ~xIcapCsib};
            if (icapSr[READ_LATENCY]) begin
                xIcapO  = icapBase + 32'(icapIdx);
                icapIdx = icapIdx + 1;
            end else begin
                xIcapO = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: append-only records read by the directed sequence.
    logic [72:0] gotQ[$];
    int          gotCyc[$];
    int issued = 0, rdwrbHigh = 0, busyHigh = 0, availViol = 0, availIdle = 0;
    always @(negedge clk) begin
        if (rstN) begin
            if (!xIcapCsib) issued = issued + 1;
            if (xIcapRdwrb) rdwrbHigh = rdwrbHigh + 1;
            if (xBusy) busyHigh = busyHigh + 1;
            if (!xIcapAvail && !xIcapCsib) availViol = availViol + 1;
            if (!xIcapAvail && xIcapCsib) availIdle = availIdle + 1;
            if (rbIf.xRb_AXIS_tvalid && rbIf.xRb_AXIS_tready) begin
                gotQ.push_back({rbIf.xRb_AXIS_tlast, rbIf.xRb_AXIS_tkeep, rbIf.xRb_AXIS_tdata});
                gotCyc.push_back(cyc);
            end
        end
    end

    logic [72:0] expQ[$];
    int cmdCyc, doneCyc, hsBase, issuedBase;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Call at posedge+#1 with the DUT idle; the handshake lands on the next edge.
    task automatic startCmd(input int count, input logic [31:0] base);
        int nb;
        logic [31:0] lo, hi;
        logic hasHi;
        expQ.delete();
        nb = (count + 1) / 2;
        for (int i = 0; i < nb; i++) begin
            lo    = base + 32'(2 * i);
            hasHi = (2 * i + 1) < count;
            hi    = hasHi ? base + 32'(2 * i + 1) : 32'h0;
            expQ.push_back({(i == nb - 1), (hasHi ? 8'hFF : 8'h0F), hi, lo});
        end
        icapBase      = base;
        icapLoad      = 1'b1;
        hsBase        = gotQ.size();
        issuedBase    = issued;
        xCmdValid     = 1'b1;
        xCmdWordCount = COUNT_W'(count);
        cmdCyc        = cyc;
        @(posedge clk);
        #1;
        xCmdValid = 1'b0;
        icapLoad  = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int maxCyc);
        logic seen;
        seen = 1'b0;
        doneCyc = -1;
        for (int i = 0; i < maxCyc && !seen; i++) begin
            @(negedge clk);
            if (xDone) begin
                seen = 1'b1;
                doneCyc = cyc;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkBeats(input string tag);
        int n;
        logic [72:0] g;
        n = gotQ.size() - hsBase;
        chk({tag, "_beat_count"}, 64'(n), 64'(expQ.size()));
        for (int i = 0; i < n && i < expQ.size(); i++) begin
            g = gotQ[hsBase + i];
            chk($sformatf("%s_beat%0d_data", tag, i), g[63:0], expQ[i][63:0]);
            chk($sformatf("%s_beat%0d_keep", tag, i), 64'(g[71:64]), 64'(expQ[i][71:64]));
            chk($sformatf("%s_beat%0d_last", tag, i), 64'(g[72]), 64'(expQ[i][72]));
        end
        if (n > 0) chk({tag, "_done_after_last"}, 64'(doneCyc), 64'(gotCyc[gotCyc.size() - 1] + 2));
    endtask

    task automatic checkResetValues(input string tag);
        chk({tag, "_cmdReady"}, 64'(xCmdReady), 64'd1);
        chk({tag, "_csib"}, 64'(xIcapCsib), 64'd1);
        chk({tag, "_rdwrb"}, 64'(xIcapRdwrb), 64'd0);
        chk({tag, "_tvalid"}, 64'(rbIf.xRb_AXIS_tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(rbIf.xRb_AXIS_tlast), 64'd0);
        chk({tag, "_tkeep"}, 64'(rbIf.xRb_AXIS_tkeep), 64'd0);
        chk({tag, "_tdata"}, rbIf.xRb_AXIS_tdata, 64'd0);
        chk({tag, "_busy"}, 64'(xBusy), 64'd0);
        chk({tag, "_done"}, 64'(xDone), 64'd0);
        chk({tag, "_state"}, 64'(dbgState), 64'(IDLE));
    endtask

    initial begin
        int snapIssued, snapRdwrb, snapBusy, snapViol, snapIdle;
        xCmdValid = 1'b0;
        xCmdWordCount = '0;
        xIcapAvail = 1'b1;
        rbIf.xRb_AXIS_tready = 1'b1;
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rstN = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // count=4: two full beats, fixed latency from handshake.
        startCmd(4, 32'hA0);
        waitDone("c4", 200);
        checkBeats("c4");
        chk("c4_data0_hand", gotQ[hsBase][63:0], 64'h000000A1_000000A0);
        chk("c4_data1_hand", gotQ[hsBase + 1][63:0], 64'h000000A3_000000A2);
        chk("c4_first_beat_cycle", 64'(gotCyc[hsBase]), 64'(cmdCyc + 8));
        chk("c4_done_cycle", 64'(doneCyc), 64'(cmdCyc + 12));

        // count=3: odd final beat.
        startCmd(3, 32'hA0);
        waitDone("c3", 200);
        checkBeats("c3");
        chk("c3_last_hand", gotQ[hsBase + 1], {1'b1, 8'h0F, 64'h00000000_000000A2});

        // count=64 with tready low for 40 cycles: 16 in FIFO plus 2 held on the bus.
        rbIf.xRb_AXIS_tready = 1'b0;
        startCmd(64, 32'h1000);
        repeat (40) @(posedge clk);
        #1;
        chk("c64_issued_under_bp", 64'(issued - issuedBase), 64'(FIFO_DEPTH + 2));
        chk("c64_no_beat_under_bp", 64'(gotQ.size() - hsBase), 64'd0);
        rbIf.xRb_AXIS_tready = 1'b1;
        waitDone("c64", 2000);
        checkBeats("c64");
        chk("c64_issued_total", 64'(issued - issuedBase), 64'd64);

        // AVAIL low for 5 cycles mid-read.
        startCmd(12, 32'h2000);
        @(posedge clk);
        #1;
        snapViol = availViol;
        snapIdle = availIdle;
        xIcapAvail = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        xIcapAvail = 1'b1;
        chk("avail_no_issue", 64'(availViol - snapViol), 64'd0);
        chk("avail_idle_cycles", 64'(availIdle - snapIdle), 64'd5);
        waitDone("avail", 500);
        checkBeats("avail");
        chk("avail_issued_total", 64'(issued - issuedBase), 64'd12);

        // count=0: immediate completion, no strobes, never busy.
        snapIssued = issued;
        snapRdwrb  = rdwrbHigh;
        snapBusy   = busyHigh;
        startCmd(0, 32'h0);
        waitDone("c0", 20);
        chk("c0_done_cycle", 64'(doneCyc), 64'(cmdCyc + 1));
        chk("c0_no_csib", 64'(issued - snapIssued), 64'd0);
        chk("c0_no_rdwrb", 64'(rdwrbHigh - snapRdwrb), 64'd0);
        chk("c0_no_busy", 64'(busyHigh - snapBusy), 64'd0);
        chk("c0_no_beats", 64'(gotQ.size() - hsBase), 64'd0);

        // Reset pulsed while reading.
        startCmd(16, 32'h3000);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_in_read", 64'(dbgState), 64'(READ));
        #1;
        rstN = 1'b0;
        #1;
        checkResetValues("rstmid");
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        #1;
        chk("rstmid_cmdReady_after", 64'(xCmdReady), 64'd1);
        @(posedge clk);
        #1;
        startCmd(2, 32'h50);
        waitDone("c2", 200);
        checkBeats("c2");
        chk("c2_beat_hand", gotQ[hsBase], {1'b1, 8'hFF, 64'h00000051_00000050});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/icap_readback_streamer.md
# icap_readback_streamer

Reads configuration data back out of the ICAPE3 primitive and delivers it upstream as a 64-bit AXI-Stream toward the PCIe bridge. It is the read-side counterpart of the PCIe-to-ICAP write stream. It owns the ICAP CSIB/RDWRB strobes during readback and the top level muxes them against the write path while xBusy is high. Issue is credit-based, so no ICAP word is lost under stream backpressure.

## Interface
- FIFO_DEPTH, 16: 32-bit word buffer entries; power of two, ≥ 2×READ_LATENCY.
- READ_LATENCY, 3: cycles from a CSIB-low read cycle to valid xIcapO.
- COUNT_W, 24: width of the word-count field.
- AxiBusClock  in  1  sole clock; all logic rising-edge.
- xAxiBusReset_n  in  1  asynchronous, active-low reset.
- xCmdValid  in  1  readback request.
- xCmdReady  out  1  high only in IDLE.
- xCmdWordCount  in  COUNT_W  32-bit words to read.
- xIcapCsib  out  1  ICAP enable, active-low.
- xIcapRdwrb  out  1  1 = read.
- xIcapAvail  in  1  ICAP AVAIL.
- xIcapO  in  32  ICAP read data.
- xRb_AXIS_tdata  out  64  word n in [31:0], word n+1 in [63:32].
- xRb_AXIS_tkeep  out  8  FF, or 0F on an odd final beat.
- xRb_AXIS_tlast  out  1  final beat of the command.
- xRb_AXIS_tvalid  out  1  beat valid.
- xRb_AXIS_tready  in  1  downstream accept.
- xBusy  out  1  high from command accept through the cycle before xDone.
- xDone  out  1  one-cycle completion pulse.

## Operation
- Reset values: xCmdReady=1, xIcapCsib=1, xIcapRdwrb=0, tvalid=0, tlast=0, tkeep=0, tdata=0, xBusy=0, xDone=0. On reset the FIFO, in-flight tracker, counters and FSM clear.
- Command handshake: xCmdValid & xCmdReady. The count is latched as `remaining` and `beats_left`, where beats_left = ceil(count/2).
- FSM states and transitions:
  - IDLE: on handshake, go to SETUP if count≠0, otherwise go to DONE.
  - SETUP: one cycle with RDWRB=1 and CSIB=1, so RDWRB never changes while CSIB is low. Then go to READ.
  - READ: drive CSIB=0 when xIcapAvail, remaining>0 and (FIFO free − in_flight) > 0. Each such cycle decrements remaining. When remaining reaches 0, go to DRAIN.
  - DRAIN: CSIB=1 and RDWRB stays 1. Wait until in_flight=0, the FIFO is empty and the last beat has handshaken. Then go to HOLD.
  - HOLD: one cycle with RDWRB=0 and CSIB=1. Then go to DONE.
  - DONE: xDone=1 for one cycle. Then go to IDLE.
- In-flight tracking:
  - A READ_LATENCY-deep shift register records each CSIB-low cycle; in_flight is its population count.
  - A 1 at its output pushes xIcapO into the FIFO.
  - Because of the credit rule the FIFO never overflows.
- xIcapAvail low: no new issue that cycle. Words already in flight still land.
- Packer:
  - Pops two words per beat.
  - Final beat: if one word is left and beats_left=1, pop it with tkeep=0F and tdata[63:32]=0.
  - tlast=1 when beats_left=1. beats_left decrements on each handshake.
- A new command is never accepted while xBusy is high.

## Timing
- Command accepted at cycle T: SETUP at T+1; first CSIB low at T+2 (if AVAIL); first word in FIFO at T+2+READ_LATENCY+1.
- First tvalid: the cycle after the FIFO holds ≥2 words, or 1 word when that word is the final one.
- Steady-state throughput with tready=1 and AVAIL=1: one ICAP word per cycle and one beat per two cycles, so the FIFO never throttles issue.
- tvalid, tdata, tkeep and tlast stay stable while tvalid=1 and tready=0.
- tvalid may assert regardless of tready.
- xDone pulses exactly 2 cycles after the last beat handshake (HOLD, then DONE). For count=0 it pulses at T+1 and no beat is emitted.
- Reset asserted mid-READ: CSIB and RDWRB return to 1 and 0 asynchronously. Any partial stream is abandoned with no tlast.

## Structure
- Package icap_rb_pkg holds:
  - the state enum: IDLE, SETUP, READ, DRAIN, HOLD, DONE;
  - ICAP_W=32 and AXIS_W=64;
  - the TKEEP_FULL and TKEEP_HALF constants.
- Sub-module icap_rb_fifo: synchronous 32-bit FIFO with first-word-fall-through and a free-count output, used for credit accounting.
- The packer and the FSM live in the top module.

## Test plan
- count=4, tready=1, AVAIL=1, xIcapO sequence 0xA0..0xA3:
  - two beats, 0x000000A1_000000A0 then 0x000000A3_000000A2;
  - tkeep FF on both, tlast on the 2nd;
  - xDone pulses 2 cycles after the 2nd beat.
- count=3: second beat is tdata=0x00000000_000000A2, tkeep=0F, tlast=1.
- count=64 with tready held low for 40 cycles:
  - CSIB stops going low once FIFO_DEPTH words are committed;
  - no word is dropped and all 32 beats arrive in order.
- AVAIL low for 5 cycles mid-read: CSIB stays high throughout, the read resumes afterwards, and the data sequence stays contiguous.
- count=0: xDone at T+1, xBusy never asserts, and CSIB and RDWRB never toggle.
- Reset pulsed during READ:
  - all outputs take their reset values immediately;
  - xCmdReady=1 after release;
  - a new count=2 command completes correctly.
